// File: rtl/udp_rio_initiator.sv
// RIO UDP initiator: periodically sends a MSGID-prefixed request frame to a
// remote node through the shared udp core. It then waits for a reply whose
// header and ID match, and latches the reply payload. Lost or bad replies end
// in a timeout that sets pkg_timeout and counts an error.
module udp_rio_initiator #(
    parameter int          BUFFER_SIZE = 80,
    parameter logic [31:0] MSGID       = 32'h74697277,
    parameter logic [31:0] REPLY_ID    = 32'h64617461,
    parameter logic [15:0] PORT        = 16'd2390,
    parameter logic [31:0] PERIOD      = 32'd50000,
    parameter logic [31:0] TIMEOUT     = 32'd25000
) (
    input  logic                   sysclk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [31:0]            remote_ip,
    input  logic [BUFFER_SIZE-1:0] tx_data,
    output logic [BUFFER_SIZE-1:0] rx_data,
    output logic                   rx_valid,
    output logic                   pkg_timeout,
    output logic [15:0]            err_count,
    output logic                   busy,
    output logic [31:0]            eth_tx_ip,
    output logic [15:0]            eth_tx_dst_port,
    output logic                   eth_tx_req,
    output logic [7:0]             eth_tx_data,
    output logic                   eth_tx_data_av,
    input  logic                   eth_tx_req_rdy,
    input  logic                   eth_tx_data_rdy,
    input  logic                   eth_rx_head_av,
    output logic                   eth_rx_head_rdy,
    input  logic [31:0]            eth_rx_head,
    input  logic                   eth_rx_data_av,
    input  logic [7:0]             eth_rx_data
);

    localparam logic [7:0] NBYTES = 8'(BUFFER_SIZE / 8);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_WAIT_TXRDY = 4'd1;
    localparam logic [3:0] S_SEND      = 4'd2;
    localparam logic [3:0] S_REQ       = 4'd3;
    localparam logic [3:0] S_WAIT_HEAD = 4'd4;
    localparam logic [3:0] S_H_IP      = 4'd5;
    localparam logic [3:0] S_H_RSV     = 4'd6;
    localparam logic [3:0] S_H_PORT    = 4'd7;
    localparam logic [3:0] S_RX        = 4'd8;
    localparam logic [3:0] S_CHECK     = 4'd9;

    logic [3:0]             state;
    logic [31:0]            period_cnt;
    logic [31:0]            to_cnt;
    logic [7:0]             tx_cnt;
    logic [7:0]             byte_cnt;
    logic [BUFFER_SIZE-1:0] tx_buf;
    logic [BUFFER_SIZE-1:0] rx_buf;
    logic [31:0]            src_ip;
    logic                   tick;
    logic                   start;
    logic                   rx_phase;
    logic                   timed_out;
    logic                   port_ok;
    logic                   reply_ok;

    assign tick      = (period_cnt == PERIOD - 32'd1);
    assign start     = (state == S_IDLE) && tick && enable;
    // Every state from WAIT_HEAD through CHECK is covered by the reply timeout.
    assign rx_phase  = (state >= S_WAIT_HEAD) && (state <= S_CHECK);
    assign timed_out = rx_phase && (to_cnt == TIMEOUT - 32'd1);
    assign port_ok   = (eth_rx_head[15:0] == PORT) && (eth_rx_head[31:16] == PORT)
                       && (src_ip == eth_tx_ip);
    assign reply_ok  = (byte_cnt == NBYTES) && (rx_buf[BUFFER_SIZE-1 -: 32] == REPLY_ID);

    assign busy           = (state != S_IDLE);
    assign eth_tx_data_av = (state == S_SEND);
    assign eth_tx_data    = (state == S_SEND) ? tx_buf[BUFFER_SIZE-1 -: 8] : 8'd0;

    // Free-running cycle timer; a tick fires on the wrap to zero.
    always_ff @(posedge sysclk) begin
        if (rst || tick) period_cnt <= 32'd0;
        else             period_cnt <= period_cnt + 32'd1;
    end

    // Frame buffers: request shift-out, reply shift-in, and header source IP.
    always_ff @(posedge sysclk) begin
        case (state)
            S_IDLE:   if (start) tx_buf <= {MSGID, tx_data[BUFFER_SIZE-33:0]};
            S_SEND:   if (eth_tx_data_rdy) tx_buf <= tx_buf << 8;
            S_H_IP:   src_ip <= eth_rx_head;
            S_H_PORT: if (port_ok) rx_buf <= '0;
            S_RX:     if (eth_rx_data_av) rx_buf <= {rx_buf[BUFFER_SIZE-9:0], eth_rx_data};
            default:  ;
        endcase
    end

    // Protocol FSM with reply timeout; a timeout overrides whatever the state would do.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            state           <= S_IDLE;
            pkg_timeout     <= 1'b1;
            err_count       <= 16'd0;
            rx_valid        <= 1'b0;
            rx_data         <= '0;
            eth_tx_req      <= 1'b0;
            eth_rx_head_rdy <= 1'b0;
            eth_tx_ip       <= 32'd0;
            eth_tx_dst_port <= 16'd0;
            to_cnt          <= 32'd0;
            tx_cnt          <= 8'd0;
            byte_cnt        <= 8'd0;
        end else begin
            rx_valid        <= 1'b0;
            eth_tx_req      <= 1'b0;
            eth_rx_head_rdy <= 1'b0;
            if (rx_phase) to_cnt <= to_cnt + 32'd1;
            if (timed_out) begin
                pkg_timeout <= 1'b1;
                if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: if (start) begin
                        eth_tx_ip       <= remote_ip;
                        eth_tx_dst_port <= PORT;
                        tx_cnt          <= 8'd0;
                        state           <= S_WAIT_TXRDY;
                    end
                    S_WAIT_TXRDY: if (eth_tx_req_rdy) state <= S_SEND;
                    S_SEND: if (eth_tx_data_rdy) begin
                        tx_cnt <= tx_cnt + 8'd1;
                        if (tx_cnt == NBYTES - 8'd1) state <= S_REQ;
                    end
                    S_REQ: if (eth_tx_req_rdy) begin
                        eth_tx_req <= 1'b1;
                        to_cnt     <= 32'd0;
                        state      <= S_WAIT_HEAD;
                    end
                    S_WAIT_HEAD: if (eth_rx_head_av) begin
                        eth_rx_head_rdy <= 1'b1;
                        state           <= S_H_IP;
                    end
                    S_H_IP:  state <= S_H_RSV;
                    S_H_RSV: state <= S_H_PORT;
                    S_H_PORT: begin
                        if (port_ok) begin
                            byte_cnt <= 8'd0;
                            state    <= S_RX;
                        end else begin
                            state <= S_WAIT_HEAD;
                        end
                    end
                    S_RX: begin
                        if (eth_rx_data_av) begin
                            if (byte_cnt != 8'hFF) byte_cnt <= byte_cnt + 8'd1;
                        end else if (byte_cnt != 8'd0) begin
                            state <= S_CHECK;
                        end
                    end
                    S_CHECK: begin
                        if (reply_ok) begin
                            rx_data     <= rx_buf;
                            rx_valid    <= 1'b1;
                            pkg_timeout <= 1'b0;
                            state       <= S_IDLE;
                        end else begin
                            state <= S_WAIT_HEAD;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_udp_rio_initiator.sv
// Directed bench for udp_rio_initiator with scoreboard queues for transmitted
// request bytes and latched reply frames.
module tb_udp_rio_initiator;

    localparam int          BS    = 80;
    localparam int          NB    = BS / 8;
    localparam int          PER   = 400;
    localparam int          TO    = 200;
    localparam logic [31:0] MSG   = 32'h74697277;
    localparam logic [31:0] RID   = 32'h64617461;
    localparam logic [31:0] PORTW = 32'h09560956;
    localparam logic [31:0] IP_A  = 32'hC0A80A05;
    localparam logic [31:0] IP_B  = 32'h0A000007;

    logic          sysclk = 1'b0;
    logic          rst;
    logic          enable;
    logic [31:0]   remote_ip;
    logic [BS-1:0] tx_data;
    logic [BS-1:0] rx_data;
    logic          rx_valid;
    logic          pkg_timeout;
    logic [15:0]   err_count;
    logic          busy;
    logic [31:0]   eth_tx_ip;
    logic [15:0]   eth_tx_dst_port;
    logic          eth_tx_req;
    logic [7:0]    eth_tx_data;
    logic          eth_tx_data_av;
    logic          eth_tx_req_rdy;
    logic          eth_tx_data_rdy;
    logic          eth_rx_head_av;
    logic          eth_rx_head_rdy;
    logic [31:0]   eth_rx_head;
    logic          eth_rx_data_av;
    logic [7:0]    eth_rx_data;

    int tests = 0;
    int fails = 0;
    int txreq_cnt = 0;
    int rxv_cnt = 0;
    bit head_rdy_seen = 0;
    bit toggle_rdy = 0;
    bit stall_prev = 0;
    logic [7:0] stall_byte;
    logic [7:0]    txq[$];
    logic [BS-1:0] rxq[$];
    logic [BS-1:0] last_good;
    logic [BS-1:0] frame;

    udp_rio_initiator #(
        .BUFFER_SIZE(BS), .MSGID(MSG), .REPLY_ID(RID), .PORT(16'd2390),
        .PERIOD(32'(PER)), .TIMEOUT(32'(TO))
    ) dut (
        .sysclk(sysclk), .rst(rst), .enable(enable), .remote_ip(remote_ip),
        .tx_data(tx_data), .rx_data(rx_data), .rx_valid(rx_valid),
        .pkg_timeout(pkg_timeout), .err_count(err_count), .busy(busy),
        .eth_tx_ip(eth_tx_ip), .eth_tx_dst_port(eth_tx_dst_port),
        .eth_tx_req(eth_tx_req), .eth_tx_data(eth_tx_data),
        .eth_tx_data_av(eth_tx_data_av), .eth_tx_req_rdy(eth_tx_req_rdy),
        .eth_tx_data_rdy(eth_tx_data_rdy), .eth_rx_head_av(eth_rx_head_av),
        .eth_rx_head_rdy(eth_rx_head_rdy), .eth_rx_head(eth_rx_head),
        .eth_rx_data_av(eth_rx_data_av), .eth_rx_data(eth_rx_data)
    );

    always #5 sysclk = ~sysclk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: observe at the falling edge, return 1 time unit after the rising edge.
    task automatic step();
        logic [7:0] e;
        @(negedge sysclk);
        if (stall_prev && eth_tx_data_av) check("tx_hold", eth_tx_data, stall_byte);
        stall_prev = eth_tx_data_av && !eth_tx_data_rdy;
        stall_byte = eth_tx_data;
        if (eth_tx_data_av && eth_tx_data_rdy) begin
            if (txq.size() == 0) check("tx_extra_byte", 1'b1, 1'b0);
            else begin
                e = txq.pop_front();
                check("tx_byte", eth_tx_data, e);
            end
        end
        if (eth_tx_req) txreq_cnt++;
        if (eth_rx_head_rdy) head_rdy_seen = 1;
        if (rx_valid) begin
            rxv_cnt++;
            if (rxq.size() == 0) check("rx_unexpected", 1'b1, 1'b0);
            else check("rx_data", rx_data, rxq.pop_front());
        end
        @(posedge sysclk);
        #1;
        if (toggle_rdy) eth_tx_data_rdy = ~eth_tx_data_rdy;
    endtask

    task automatic start_request(input logic [31:0] ip, input logic [BS-1:0] txd);
        logic [BS-1:0] exp;
        remote_ip = ip;
        tx_data = txd;
        exp = {MSG, txd[BS-33:0]};
        for (int i = 0; i < NB; i++) txq.push_back(exp[BS-1-8*i -: 8]);
        enable = 1'b1;
        for (int i = 0; i < PER + 10 && !busy; i++) step();
        enable = 1'b0;
        check("start_busy", busy, 1'b1);
        check("tx_ip", eth_tx_ip, ip);
        check("tx_port", eth_tx_dst_port, 16'd2390);
    endtask

    task automatic wait_txreq();
        int c0;
        c0 = txreq_cnt;
        for (int i = 0; i < 200 && txreq_cnt == c0; i++) step();
        check("txreq_pulse", txreq_cnt, c0 + 1);
        check("tx_all_bytes", txq.size(), 0);
    endtask

    task automatic send_header(input logic [31:0] ip, input logic [31:0] pw);
        head_rdy_seen = 0;
        eth_rx_head_av = 1'b1;
        eth_rx_head = ip;
        for (int i = 0; i < 20 && !head_rdy_seen; i++) step();
        check("head_rdy", head_rdy_seen, 1'b1);
        eth_rx_head_av = 1'b0;
        eth_rx_head = 32'd0;
        step();
        eth_rx_head = pw;
        step();
        eth_rx_head = 32'd0;
    endtask

    task automatic send_reply(input logic [31:0] ip, input logic [31:0] pw,
                              input logic [BS-1:0] f, input int n, input bit expv);
        if (expv) rxq.push_back(f);
        send_header(ip, pw);
        for (int i = 0; i < n; i++) begin
            eth_rx_data_av = 1'b1;
            eth_rx_data = f[BS-1-8*i -: 8];
            step();
        end
        eth_rx_data_av = 1'b0;
        eth_rx_data = 8'd0;
        repeat (3) step();
    endtask

    function automatic logic [BS-1:0] rnd_frame(input logic [31:0] id);
        return {id, $urandom, 16'($urandom)};
    endfunction

    initial begin
        int rv0;
        int rq0;
        bit busy_seen;
        rst = 1'b1; enable = 1'b0; remote_ip = 32'd0; tx_data = '0;
        eth_tx_req_rdy = 1'b1; eth_tx_data_rdy = 1'b1;
        eth_rx_head_av = 1'b0; eth_rx_head = 32'd0;
        eth_rx_data_av = 1'b0; eth_rx_data = 8'd0;
        last_good = '0;
        repeat (3) step();
        check("rst_busy", busy, 1'b0);
        check("rst_pkg_timeout", pkg_timeout, 1'b1);
        check("rst_err_count", err_count, 16'd0);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_rx_data", rx_data, '0);
        check("rst_tx_req", eth_tx_req, 1'b0);
        check("rst_tx_av", eth_tx_data_av, 1'b0);
        check("rst_tx_ip", eth_tx_ip, 32'd0);
        check("rst_head_rdy", eth_rx_head_rdy, 1'b0);
        rst = 1'b0;

        // 1: zero payload request, valid reply
        start_request(IP_A, '0);
        wait_txreq();
        frame = rnd_frame(RID);
        send_reply(IP_A, PORTW, frame, NB, 1'b1);
        last_good = frame;
        check("t1_rxv_count", rxv_cnt, 1);
        check("t1_rx_data", rx_data, frame);
        check("t1_pkg_timeout", pkg_timeout, 1'b0);
        check("t1_idle", busy, 1'b0);

        // 2: no reply, timeout exactly TIMEOUT cycles after tx_req
        start_request(IP_A, rnd_frame($urandom));
        wait_txreq();
        repeat (TO - 2) step();
        check("t2_busy_before", busy, 1'b1);
        check("t2_pkg_before", pkg_timeout, 1'b0);
        step();
        check("t2_busy_after", busy, 1'b0);
        check("t2_pkg_after", pkg_timeout, 1'b1);
        check("t2_err_count", err_count, 16'd1);

        // 3: wrong port ignored, following correct reply latched
        start_request(IP_A, rnd_frame($urandom));
        wait_txreq();
        rv0 = rxv_cnt;
        send_reply(IP_A, 32'h09560957, rnd_frame(RID), NB, 1'b0);
        check("t3_wrong_port_busy", busy, 1'b1);
        frame = rnd_frame(RID);
        send_reply(IP_A, PORTW, frame, NB, 1'b1);
        last_good = frame;
        check("t3_rxv_count", rxv_cnt, rv0 + 1);
        check("t3_rx_data", rx_data, frame);
        check("t3_err_count", err_count, 16'd1);
        check("t3_pkg_timeout", pkg_timeout, 1'b0);

        // 4a: bad reply ID ends in timeout
        start_request(IP_A, rnd_frame($urandom));
        wait_txreq();
        rv0 = rxv_cnt;
        send_reply(IP_A, PORTW, rnd_frame(32'hDEADBEEF), NB, 1'b0);
        for (int i = 0; i < TO + 20 && busy; i++) step();
        check("t4a_idle", busy, 1'b0);
        check("t4a_rxv_count", rxv_cnt, rv0);
        check("t4a_rx_data", rx_data, last_good);
        check("t4a_err_count", err_count, 16'd2);
        check("t4a_pkg_timeout", pkg_timeout, 1'b1);

        // 4b: short (9 byte) reply ends in timeout
        start_request(IP_B, rnd_frame($urandom));
        wait_txreq();
        send_reply(IP_B, PORTW, rnd_frame(RID), NB - 1, 1'b0);
        for (int i = 0; i < TO + 20 && busy; i++) step();
        check("t4b_idle", busy, 1'b0);
        check("t4b_rxv_count", rxv_cnt, rv0);
        check("t4b_rx_data", rx_data, last_good);
        check("t4b_err_count", err_count, 16'd3);

        // 5: data ready toggling every cycle during transmit
        toggle_rdy = 1;
        start_request(IP_B, rnd_frame($urandom));
        wait_txreq();
        toggle_rdy = 0;
        eth_tx_data_rdy = 1'b1;
        frame = rnd_frame(RID);
        send_reply(IP_B, PORTW, frame, NB, 1'b1);
        last_good = frame;
        check("t5_rx_data", rx_data, frame);
        check("t5_err_count", err_count, 16'd3);

        // 6: reset while receiving, then no requests with enable low
        start_request(IP_A, rnd_frame($urandom));
        wait_txreq();
        send_header(IP_A, PORTW);
        for (int i = 0; i < 3; i++) begin
            eth_rx_data_av = 1'b1;
            eth_rx_data = 8'(i + 1);
            step();
        end
        rst = 1'b1;
        step();
        check("t6_busy", busy, 1'b0);
        check("t6_pkg_timeout", pkg_timeout, 1'b1);
        check("t6_err_count", err_count, 16'd0);
        check("t6_tx_req", eth_tx_req, 1'b0);
        check("t6_rx_valid", rx_valid, 1'b0);
        check("t6_rx_data", rx_data, '0);
        rst = 1'b0;
        eth_rx_data_av = 1'b0;
        rq0 = txreq_cnt;
        busy_seen = 0;
        for (int i = 0; i < 2 * PER + 20; i++) begin
            step();
            if (busy) busy_seen = 1;
        end
        check("t6_no_busy", busy_seen, 1'b0);
        check("t6_no_txreq", txreq_cnt, rq0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/udp_rio_initiator.md
Name: udp_rio_initiator

Overview:
Initiator end of the RIO UDP request/reply protocol. It sits on the host/master FPGA in front of the shared `udp` core. It sends a fixed-size request frame, prefixed with MSGID, to a remote RIO node. It then waits for the node's reply and validates the reply ID, latching the payload on a match. Periodic cycling, lost-reply timeout and error counting let it poll remote I/O nodes without a PC.

Parameters:
BUFFER_SIZE, 80, frame size in bits; multiple of 8, at least 40.
MSGID, 32'h74697277, request ID, forced into bits [BUFFER_SIZE-1:BUFFER_SIZE-32] of every request.
REPLY_ID, 32'h64617461, required value of reply bits [BUFFER_SIZE-1:BUFFER_SIZE-32].
PORT, 16'd2390, local UDP source port and remote destination port.
PERIOD, 32'd50000, sysclk cycles between request starts.
TIMEOUT, 32'd25000, sysclk cycles allowed from tx_req pulse to valid reply; must be less than PERIOD.

Ports:
sysclk  in  1  clock; same clock as the udp core's clk50m.
rst  in  1  synchronous, active-high reset.
enable  in  1  allows new cycles to start; a cycle already in progress completes.
remote_ip  in  32  destination IP; sampled at cycle start.
tx_data  in  BUFFER_SIZE  request payload; sampled at cycle start; top 32 bits are replaced by MSGID.
rx_data  out  BUFFER_SIZE  last valid reply.
rx_valid  out  1  one-cycle pulse when rx_data updates.
pkg_timeout  out  1  high after a cycle ends without a valid reply; cleared by the next valid reply.
err_count  out  16  count of failed cycles; saturates at 16'hFFFF.
busy  out  1  high in any state other than IDLE.
eth_tx_ip, eth_tx_dst_port  out  32/16  to the udp core; held at the sampled remote_ip and at PORT.
eth_tx_req  out  1  one-cycle transmit request.
eth_tx_data  out  8  transmit byte.
eth_tx_data_av  out  1  transmit byte valid.
eth_tx_req_rdy, eth_tx_data_rdy  in  1  udp core ready inputs.
eth_rx_head_av  in  1  receive header available.
eth_rx_head_rdy  out  1  receive header acknowledge.
eth_rx_head  in  32  receive header word.
eth_rx_data_av  in  1  receive byte valid.
eth_rx_data  in  8  receive byte.

Behaviour:
- Reset values: all outputs 0 except pkg_timeout=1. period_cnt=0; state=IDLE.
- period_cnt runs freely. It wraps to 0 at PERIOD-1 and emits a tick.
- FSM states and transitions:
  - IDLE: on tick with enable=1, sample remote_ip and tx_data into tx_buf (top 32 bits = MSGID), then go to WAIT_TXRDY.
  - WAIT_TXRDY: wait for eth_tx_req_rdy=1, then go to SEND.
  - SEND: present tx_buf[BUFFER_SIZE-1 -: 8] with eth_tx_data_av=1.
    - A byte is consumed in a cycle where eth_tx_data_av and eth_tx_data_rdy are both 1; on consume, shift tx_buf left by 8.
    - While eth_tx_data_rdy=0, hold the byte and keep eth_tx_data_av=1.
    - After byte BUFFER_SIZE/8 is consumed, drop eth_tx_data_av and go to REQ.
  - REQ: when eth_tx_req_rdy=1, pulse eth_tx_req for 1 cycle, clear to_cnt, and go to WAIT_HEAD.
  - WAIT_HEAD: on eth_rx_head_av, pulse eth_rx_head_rdy for 1 cycle and go to H_IP.
  - H_IP: capture eth_rx_head as src_ip.
  - H_RSV: skip this header word.
  - H_PORT: accept the header only if eth_rx_head[15:0]==PORT, eth_rx_head[31:16]==PORT and src_ip==sampled remote_ip.
    - On accept: clear rx_buf and byte_cnt, go to RX.
    - On reject: go back to WAIT_HEAD; the payload of the rejected frame is ignored.
  - RX: each cycle with eth_rx_data_av=1, set rx_buf={rx_buf[BUFFER_SIZE-9:0], eth_rx_data} and increment byte_cnt (saturating at 255).
    - The first cycle with eth_rx_data_av=0 after byte_cnt>0 goes to CHECK.
  - CHECK (1 cycle):
    - Valid means byte_cnt==BUFFER_SIZE/8 and rx_buf top 32 bits==REPLY_ID.
    - Valid: rx_data<=rx_buf, rx_valid pulses, pkg_timeout<=0, go to IDLE.
    - Invalid: go to WAIT_HEAD; to_cnt keeps running.
- Timeout:
  - to_cnt increments in WAIT_HEAD through CHECK.
  - When to_cnt reaches TIMEOUT in any of those states: pkg_timeout<=1, err_count+=1 (saturating), state<=IDLE.
  - A timeout has priority over a CHECK completing in the same cycle.
- Ticks: a tick while busy is dropped; no queueing.
- eth_rx_data_av=1 while not in RX: the byte is ignored.
- Reset mid-operation: outputs return to reset values immediately on the next edge, and any partial frame is abandoned.
- Latency: the first eth_tx_data_av comes at the earliest 2 cycles after the tick.

Test Plan:
1. BUFFER_SIZE=80, tx_data=80'h0, ready inputs always 1, tick -> 10 bytes, first four 74 69 72 77, then tx_req pulses once. The model replies 10 bytes from the matching IP with port word 32'h09560956 and top 32 bits 64617461. Required: rx_valid pulses once, rx_data equals the reply, pkg_timeout=0.
2. No reply -> exactly TIMEOUT cycles after tx_req: pkg_timeout=1, err_count=1, busy=0. The next tick starts a new request.
3. Reply on wrong port (dst 2391), then a correct reply -> the first is ignored, the second is latched. err_count is unchanged.
4. Reply with a bad ID (top 32 bits 0xDEADBEEF) or only 9 bytes -> no rx_valid, rx_data unchanged. The cycle ends in timeout with err_count incremented.
5. eth_tx_data_rdy toggling 1/0 every cycle -> the byte sequence is unchanged with no dropped or duplicated bytes; eth_tx_data is held during stalls.
6. rst asserted during the RX state -> next edge: busy=0, pkg_timeout=1, err_count=0, eth_tx_req=0. With enable=0, no request is sent even on ticks.
